imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory that the fetch stage reads: receives a program image as a byte stream over a valid/ready link and writes 16-bit instruction words into instruction memory.
- Holds the processor core in reset (cpu_hold) while loading, and releases it only after the final word is committed.
- Sits between the host/UART byte receiver and the instruction-memory write port.

Parameters:
- DEPTH, 256, instruction memory size in words; this is the maximum legal word count.
- BASE_ADDR, 16'h0000, memory address of the first loaded word.
- TIMEOUT, 1000, maximum idle cycles between accepted bytes once loading has started; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader can accept a byte.
- imem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- imem_addr  output  16  write address.
- imem_wdata  output  16  write data (instruction word).
- cpu_hold  output  1  1 = core held in reset / PC frozen.
- done  output  1  level; the load completed successfully.
- err  output  1  level; the load was aborted (oversize count or timeout).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_hold=1, done=0, err=0.
  - Word index and timeout counter are cleared.
  - Reset mid-load aborts immediately. Words already written remain in memory.
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words, high byte first.
- A byte is accepted on a rising edge where rx_valid && rx_ready. rx_ready=1 only in LEN_HI, LEN_LO, DAT_HI and DAT_LO; 0 in all other states.
- States and transitions:
  - IDLE: on start -> LEN_HI.
  - LEN_HI: on accept, latch the high byte -> LEN_LO.
  - LEN_LO: on accept, form N. N=0 -> DONE. N>DEPTH -> ERR, with no writes performed. Otherwise clear index -> DAT_HI.
  - DAT_HI: on accept, latch the high byte -> DAT_LO.
  - DAT_LO: on accept, register the write. If index==N-1 -> FLUSH; else -> DAT_HI and increment index.
  - FLUSH: one cycle -> DONE.
  - DONE: done=1, cpu_hold=0. On start -> LEN_HI with done=0 and cpu_hold=1 from the next cycle.
  - ERR: err=1, cpu_hold=1. On start -> LEN_HI with err=0.
- start in any other state is ignored.
- Write timing:
  - The cycle after a DAT_LO accept: imem_we=1 for exactly one cycle, imem_addr=BASE_ADDR+index (16-bit, wraps mod 2^16), imem_wdata={hi,lo}.
  - imem_addr and imem_wdata hold their last values while imem_we=0.
  - A byte may be accepted in DAT_HI during the same cycle as the previous word's write pulse.
- Release ordering:
  - The final write pulse coincides with the FLUSH cycle.
  - done=1 and cpu_hold=0 occur one cycle later, so the core never fetches before the last write is committed.
- Timeout:
  - Counter runs in LEN_LO, DAT_HI and DAT_LO. It clears on every accepted byte and on state entry.
  - When it reaches TIMEOUT with no accept -> ERR. Words already written stay in memory.
  - LEN_HI waits indefinitely.
- Back-to-back throughput: one byte per cycle when rx_valid is held high.

Test Plan:
- Reset released, start, bytes 00 03 | 12 34 | AB CD | 00 07 with valid held high -> three imem_we pulses: (0000,1234), (0001,ABCD), (0002,0007). done=1 and cpu_hold=0 one cycle after the third pulse. rx_ready=0 afterwards.
- Count 0 (bytes 00 00) -> no imem_we; DONE the cycle after LEN_LO accept; cpu_hold=0.
- Count DEPTH+1 (01 01 with DEPTH=256) -> ERR, err=1, cpu_hold=1, zero writes. A subsequent start followed by a valid 1-word image -> err=0, one write, done=1.
- rx_valid toggled randomly during a 4-word load -> write order and values unchanged; no byte lost or duplicated; imem_we never high for two consecutive cycles with the same address.
- TIMEOUT=10: send 00 02 12, then stall for 10 cycles -> ERR on the 10th idle cycle, no write for the partial word. Repeat with a 9-cycle stall -> load completes normally.
- rst pulsed low in the middle of word 2 of 4 -> all outputs return to reset values asynchronously. Word 1 remains in memory; the next start performs a clean reload from BASE_ADDR.

Source files
------------

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Writer side of the instruction memory. Receives a program image as a byte
// stream over a valid/ready link and writes 16-bit instruction words into the
// instruction memory, holding the core in reset until the final word has been
// committed.
//
// Stream format: LEN_HI, LEN_LO (big-endian word count N), then N words, each
// sent high byte first.
//
// Parameters:
//   DEPTH      instruction memory size in words; largest legal word count
//   BASE_ADDR  memory address of the first loaded word
//   TIMEOUT    max idle cycles between accepted bytes once loading has
//              started (LEN_LO/DAT_HI/DAT_LO); 0 disables the timeout
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   start       one-cycle pulse starting a load (honoured in IDLE/DONE/ERR)
//   rx_data     incoming byte
//   rx_valid    rx_data is valid
//   rx_ready    loader can accept a byte
//   imem_we     instruction memory write enable, one-cycle pulse per word
//   imem_addr   write address (held while imem_we is low)
//   imem_wdata  write data (held while imem_we is low)
//   cpu_hold    1 = core held in reset / PC frozen
//   done        level, load completed successfully
//   err         level, load aborted (oversize count or timeout)
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int unsigned  DEPTH     = 256,
    parameter logic [15:0]  BASE_ADDR = 16'h0000,
    parameter int unsigned  TIMEOUT   = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [15:0] imem_addr,
    output logic [15:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DAT_HI,
        S_DAT_LO,
        S_FLUSH,
        S_DONE,
        S_ERR
    } state_t;

    // Idle counter only needs to reach TIMEOUT-1.
    localparam int unsigned    TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]  TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    state_t        state_q,    state_d;
    logic [7:0]    len_hi_q,   len_hi_d;
    logic [15:0]   len_q,      len_d;
    logic [15:0]   idx_q,      idx_d;
    logic [7:0]    dhi_q,      dhi_d;
    logic [TW-1:0] tcnt_q,     tcnt_d;
    logic          rx_ready_q, rx_ready_d;
    logic          we_q,       we_d;
    logic [15:0]   addr_q,     addr_d;
    logic [15:0]   wdata_q,    wdata_d;
    logic          hold_q,     hold_d;
    logic          done_q,     done_d;
    logic          err_q,      err_d;

    logic          accept;
    logic          timed;
    logic [15:0]   len_word;

    assign accept   = rx_valid && rx_ready_q;
    assign len_word = {len_hi_q, rx_data};
    assign timed    = (state_q == S_LEN_LO) || (state_q == S_DAT_HI) ||
                      (state_q == S_DAT_LO);

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        idx_d    = idx_q;
        dhi_d    = dhi_q;
        tcnt_d   = '0;          // cleared on accept and on every state entry
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_hi_d = rx_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    if (len_word == 16'd0) begin
                        state_d = S_DONE;
                    end else if (32'(len_word) > DEPTH) begin
                        state_d = S_ERR;
                    end else begin
                        len_d   = len_word;
                        idx_d   = '0;
                        state_d = S_DAT_HI;
                    end
                end
            end
            S_DAT_HI: begin
                if (accept) begin
                    dhi_d   = rx_data;
                    state_d = S_DAT_LO;
                end
            end
            S_DAT_LO: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = BASE_ADDR + idx_q;
                    wdata_d = {dhi_q, rx_data};
                    if (idx_q == len_q - 16'd1) begin
                        state_d = S_FLUSH;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        state_d = S_DAT_HI;
                    end
                end
            end
            // Final write pulse is on the bus during this cycle; release
            // happens only after it.
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        if (timed && !accept && (TIMEOUT != 0)) begin
            if (tcnt_q == TO_LAST) begin
                state_d = S_ERR;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    always_comb begin
        rx_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                     (state_d == S_DAT_HI) || (state_d == S_DAT_LO);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
        hold_d     = (state_d != S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            len_hi_q   <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            dhi_q      <= '0;
            tcnt_q     <= '0;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            dhi_q      <= dhi_d;
            tcnt_q     <= tcnt_d;
            rx_ready_q <= rx_ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    imem_loader #(
        .DEPTH     (256),
        .BASE_ADDR (16'h0000),
        .TIMEOUT   (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_mis = 0;

    typedef struct {
        logic        st;
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wd;
        logic        hold;
        logic        dn;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic v, input logic [7:0] d,
                                input logic rdy, input logic we, input logic [15:0] addr,
                                input logic [15:0] wd, input logic hold, input logic dn,
                                input logic er);
        vec_t r;
        r.st = st; r.v = v; r.d = d; r.rdy = rdy; r.we = we; r.addr = addr;
        r.wd = wd; r.hold = hold; r.dn = dn; r.er = er;
        return r;
    endfunction

    // Write monitor: log of (addr,data) per write pulse plus a check for
    // back-to-back pulses to the same address.
    logic [31:0] wlog[$];
    logic        prev_we = 1'b0;
    logic [15:0] prev_addr = 16'h0;
    int          dup_cnt = 0;

    always @(negedge clk) begin
        if (imem_we) begin
            wlog.push_back({imem_addr, imem_wdata});
            if (prev_we && prev_addr == imem_addr) dup_cnt++;
        end
        prev_we   = imem_we;
        prev_addr = imem_addr;
    end

    function automatic logic [36:0] outs();
        return {rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err};
    endfunction

    localparam logic [36:0] RESET_OUTS = {1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    logic [7:0] txq[$];

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Sends txq; with rnd set, rx_valid is randomly dropped (never more than
    // four idle cycles in a row so the timeout cannot fire).
    task automatic send_txq(input bit rnd);
        int  gap = 0;
        int  budget = 300;
        logic acc;
        while (txq.size() > 0 && budget > 0) begin
            rx_data = txq[0];
            if (rnd && gap < 4) rx_valid = 1'($urandom_range(0, 1));
            else                rx_valid = 1'b1;
            acc = rx_valid && rx_ready;
            @(posedge clk); #1;
            if (acc) begin
                void'(txq.pop_front());
                gap = 0;
            end else begin
                gap++;
            end
            budget--;
        end
        rx_valid = 1'b0;
        chk("bytes_consumed", 64'(txq.size()), 64'd0);
        txq.delete();
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_reached", 64'(done), 64'd1);
    endtask

    task automatic chk_wr(input string nm, input int idx, input logic [31:0] exp);
        logic [31:0] got;
        got = (idx < wlog.size()) ? wlog[idx] : 32'hxxxx_xxxx;
        chk(nm, 64'(got), 64'(exp));
    endtask

    initial begin
        int base;
        rst      = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 64'(outs()), 64'(RESET_OUTS));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_start", 64'(outs()), 64'(RESET_OUTS));

        // 3-word load, back-to-back bytes
        vecs.push_back(mk(1,0,8'h00, 1,0,16'h0000,16'h0000, 1,0,0));
        vecs.push_back(mk(0,1,8'h00, 1,0,16'h0000,16'h0000, 1,0,0));
        vecs.push_back(mk(0,1,8'h03, 1,0,16'h0000,16'h0000, 1,0,0));
        vecs.push_back(mk(0,1,8'h12, 1,0,16'h0000,16'h0000, 1,0,0));
        vecs.push_back(mk(0,1,8'h34, 1,1,16'h0000,16'h1234, 1,0,0));
        vecs.push_back(mk(0,1,8'hAB, 1,0,16'h0000,16'h1234, 1,0,0));
        vecs.push_back(mk(0,1,8'hCD, 1,1,16'h0001,16'hABCD, 1,0,0));
        vecs.push_back(mk(0,1,8'h00, 1,0,16'h0001,16'hABCD, 1,0,0));
        vecs.push_back(mk(0,1,8'h07, 0,1,16'h0002,16'h0007, 1,0,0));
        vecs.push_back(mk(0,1,8'hEE, 0,0,16'h0002,16'h0007, 0,1,0));
        vecs.push_back(mk(0,0,8'h00, 0,0,16'h0002,16'h0007, 0,1,0));
        // count 0 -> DONE straight from LEN_LO
        vecs.push_back(mk(1,0,8'h00, 1,0,16'h0002,16'h0007, 1,0,0));
        vecs.push_back(mk(0,1,8'h00, 1,0,16'h0002,16'h0007, 1,0,0));
        vecs.push_back(mk(0,1,8'h00, 0,0,16'h0002,16'h0007, 0,1,0));
        vecs.push_back(mk(0,0,8'h00, 0,0,16'h0002,16'h0007, 0,1,0));
        // count DEPTH+1 -> ERR, then a 1-word reload (start in DAT_HI ignored)
        vecs.push_back(mk(1,0,8'h00, 1,0,16'h0002,16'h0007, 1,0,0));
        vecs.push_back(mk(0,1,8'h01, 1,0,16'h0002,16'h0007, 1,0,0));
        vecs.push_back(mk(0,1,8'h01, 0,0,16'h0002,16'h0007, 1,0,1));
        vecs.push_back(mk(0,1,8'h55, 0,0,16'h0002,16'h0007, 1,0,1));
        vecs.push_back(mk(1,0,8'h00, 1,0,16'h0002,16'h0007, 1,0,0));
        vecs.push_back(mk(0,1,8'h00, 1,0,16'h0002,16'h0007, 1,0,0));
        vecs.push_back(mk(0,1,8'h01, 1,0,16'h0002,16'h0007, 1,0,0));
        vecs.push_back(mk(1,1,8'h5A, 1,0,16'h0002,16'h0007, 1,0,0));
        vecs.push_back(mk(0,1,8'hA5, 0,1,16'h0000,16'h5AA5, 1,0,0));
        vecs.push_back(mk(0,0,8'h00, 0,0,16'h0000,16'h5AA5, 0,1,0));

        for (int i = 0; i < vecs.size(); i++) begin
            start    = vecs[i].st;
            rx_valid = vecs[i].v;
            rx_data  = vecs[i].d;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), 64'(outs()),
                64'({vecs[i].rdy, vecs[i].we, vecs[i].addr, vecs[i].wd,
                     vecs[i].hold, vecs[i].dn, vecs[i].er}));
        end
        start    = 1'b0;
        rx_valid = 1'b0;

        // 4-word load with randomly gapped rx_valid
        base = wlog.size();
        pulse_start();
        txq = '{8'h00, 8'h04, 8'h01, 8'h02, 8'hC0, 8'hDE, 8'hF0, 8'h0D, 8'h7F, 8'hFF};
        send_txq(1);
        wait_done();
        chk("rand_nwrites", 64'(wlog.size() - base), 64'd4);
        chk_wr("rand_w0", base + 0, {16'h0000, 16'h0102});
        chk_wr("rand_w1", base + 1, {16'h0001, 16'hC0DE});
        chk_wr("rand_w2", base + 2, {16'h0002, 16'hF00D});
        chk_wr("rand_w3", base + 3, {16'h0003, 16'h7FFF});
        chk("rand_dup_we", 64'(dup_cnt), 64'd0);
        chk("rand_hold", 64'(cpu_hold), 64'd0);

        // Timeout: 10 idle cycles mid-word -> ERR, no partial write
        base = wlog.size();
        pulse_start();
        txq = '{8'h00, 8'h02, 8'h12};
        send_txq(0);
        repeat (9) begin @(posedge clk); #1; end
        chk("to_err_after9", 64'(err), 64'd0);
        @(posedge clk); #1;
        chk("to_err_after10", 64'({err, cpu_hold, rx_ready, done}), 64'(4'b1100));
        chk("to_nowrite", 64'(wlog.size() - base), 64'd0);

        // 9 idle cycles is tolerated
        base = wlog.size();
        pulse_start();
        chk("to_err_cleared", 64'(err), 64'd0);
        txq = '{8'h00, 8'h02, 8'h12};
        send_txq(0);
        repeat (9) begin @(posedge clk); #1; end
        chk("stall9_err", 64'(err), 64'd0);
        txq = '{8'h34, 8'h56, 8'h78};
        send_txq(0);
        wait_done();
        chk("stall9_nwrites", 64'(wlog.size() - base), 64'd2);
        chk_wr("stall9_w0", base + 0, {16'h0000, 16'h1234});
        chk_wr("stall9_w1", base + 1, {16'h0001, 16'h5678});

        // Asynchronous reset in the middle of word 2 of 4
        base = wlog.size();
        pulse_start();
        txq = '{8'h00, 8'h04, 8'h12, 8'h34, 8'hAA};
        send_txq(0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_outputs", 64'(outs()), 64'(RESET_OUTS));
        chk("rst_nwrites", 64'(wlog.size() - base), 64'd1);
        chk_wr("rst_word1", base, {16'h0000, 16'h1234});
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_idle", 64'(outs()), 64'(RESET_OUTS));
        base = wlog.size();
        pulse_start();
        txq = '{8'h00, 8'h01, 8'hBE, 8'hEF};
        send_txq(0);
        wait_done();
        chk("reload_nwrites", 64'(wlog.size() - base), 64'd1);
        chk_wr("reload_w0", base, {16'h0000, 16'hBEEF});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
